// File: rtl/bp_update_sched_pkg.sv
// ---------------------------------------------------------------------------
// bp_update_sched_pkg
// Shared widths and entry layout for the branch-update scheduler.
// An entry packs one resolved branch as:
//   [SRC_LSB +: INS_W]  branch PC
//   [TGT_LSB +: INS_W]  resolved target PC
//   [4:0]               taken, call, ret, jmp, mispredict flags
// ---------------------------------------------------------------------------
package bp_update_sched_pkg;

  // Instruction address bus width (INS_BUS_A).
  localparam int INS_W = 32;

  // Flag bit offsets within a queue entry.
  localparam int BPQ_TAKEN_BIT = 0;
  localparam int BPQ_CALL_BIT  = 1;
  localparam int BPQ_RET_BIT   = 2;
  localparam int BPQ_JMP_BIT   = 3;
  localparam int BPQ_MP_BIT    = 4;

  // Address field offsets within a queue entry.
  localparam int BPQ_SRC_LSB   = 5;
  localparam int BPQ_TGT_LSB   = BPQ_SRC_LSB + INS_W;

  // Total entry width: two addresses plus five flags (69 bits).
  localparam int BPQ_ENTRY_W   = 2 * INS_W + 5;

endpackage

// File: rtl/bpq_fifo.sv
// ---------------------------------------------------------------------------
// bpq_fifo
// Synchronous in-order FIFO with registered occupancy.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   push, push_data    write request and data (ignored when full)
//   pop                read request (ignored when empty)
//   pop_data           head entry, all zero when empty
//   full, empty        decoded from the registered count
//   count              occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module bpq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_AW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: storage has no reset; the count alone decides which entries are
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_AW'(1);
        2'b01:   count <= count - CNT_AW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == CNT_AW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bp_update_sched.sv
// ---------------------------------------------------------------------------
// bp_update_sched
// Buffers resolved branches from execute and drains them, one per cycle and
// strictly in order, onto the branch predictor's single update port.
// Ports:
//   ck_i, rs_i                 clock, asynchronous active-high reset
//   ex_valid_i / ex_ready_o    execute handshake (ready = not full)
//   ex_source_i, ex_target_i   branch PC and resolved target
//   ex_*_i flags               taken, call, ret, jmp, mispredict
//   hold_i                     pause draining; head entry is kept
//   branch_request_o           update strobe (non-empty and not held)
//   branch_*_o                 head entry fields, zero when empty
//   mp_pending_o               a queued entry is a mispredict
//   empty_o                    queue empty
//   retired_cnt_o              updates issued (wraps)
//   mispred_cnt_o              mispredict updates issued (wraps)
// ---------------------------------------------------------------------------
module bp_update_sched
  import bp_update_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             ck_i,
  input  logic             rs_i,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [INS_W-1:0] ex_source_i,
  input  logic [INS_W-1:0] ex_target_i,
  input  logic             ex_taken_i,
  input  logic             ex_call_i,
  input  logic             ex_ret_i,
  input  logic             ex_jmp_i,
  input  logic             ex_mispredict_i,
  input  logic             hold_i,
  output logic             branch_request_o,
  output logic [INS_W-1:0] branch_source_o,
  output logic [INS_W-1:0] branch_target_o,
  output logic             branch_is_taken_o,
  output logic             branch_is_call_o,
  output logic             branch_is_ret_o,
  output logic             branch_is_jmp_o,
  output logic             branch_mispredict_o,
  output logic             mp_pending_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int CNT_AW = $clog2(DEPTH+1);

  logic [BPQ_ENTRY_W-1:0] push_bits;
  logic [BPQ_ENTRY_W-1:0] head_bits;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_AW-1:0]      fifo_count;
  logic [CNT_AW-1:0]      mp_cnt;
  logic                   push;
  logic                   pop;
  logic                   head_mp;

  // Ready looks only at registered fullness, never at this cycle's pop, so
  // there is no combinational path from hold_i into ex_ready_o.
  assign ex_ready_o = ~fifo_full;
  assign push       = ex_valid_i & ex_ready_o;

  // The request depends only on hold_i and the registered empty flag.
  assign pop              = ~fifo_empty & ~hold_i;
  assign branch_request_o = pop;
  assign empty_o          = fifo_empty;

  // NOTE: every bit gets a default before the field writes, so no latch is
  // inferred for bits a later edit might forget to assign.
  always_comb begin
    push_bits                                = '0;
    push_bits[BPQ_SRC_LSB +: INS_W]          = ex_source_i;
    push_bits[BPQ_TGT_LSB +: INS_W]          = ex_target_i;
    push_bits[BPQ_TAKEN_BIT]                 = ex_taken_i;
    push_bits[BPQ_CALL_BIT]                  = ex_call_i;
    push_bits[BPQ_RET_BIT]                   = ex_ret_i;
    push_bits[BPQ_JMP_BIT]                   = ex_jmp_i;
    push_bits[BPQ_MP_BIT]                    = ex_mispredict_i;
  end

  bpq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BPQ_ENTRY_W)
  ) u_fifo (
    .clk       (ck_i),
    .rst       (rs_i),
    .push      (push),
    .push_data (push_bits),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The FIFO already zeroes its output when empty, so fields are plain slices.
  assign branch_source_o     = head_bits[BPQ_SRC_LSB +: INS_W];
  assign branch_target_o     = head_bits[BPQ_TGT_LSB +: INS_W];
  assign branch_is_taken_o   = head_bits[BPQ_TAKEN_BIT];
  assign branch_is_call_o    = head_bits[BPQ_CALL_BIT];
  assign branch_is_ret_o     = head_bits[BPQ_RET_BIT];
  assign branch_is_jmp_o     = head_bits[BPQ_JMP_BIT];
  assign branch_mispredict_o = head_bits[BPQ_MP_BIT];
  assign head_mp             = head_bits[BPQ_MP_BIT];

  // Number of queued mispredicts; a queued mispredict entry pushed and
  // another popped in the same cycle cancel out.
  always_ff @(posedge ck_i or posedge rs_i) begin
    if (rs_i) begin
      mp_cnt <= '0;
    end else begin
      case ({push & ex_mispredict_i, pop & head_mp})
        2'b10:   mp_cnt <= mp_cnt + CNT_AW'(1);
        2'b01:   mp_cnt <= mp_cnt - CNT_AW'(1);
        default: mp_cnt <= mp_cnt;
      endcase
    end
  end

  assign mp_pending_o = (mp_cnt != '0);

  // Performance counters wrap naturally at 2^CNT_W.
  always_ff @(posedge ck_i or posedge rs_i) begin
    if (rs_i) begin
      retired_cnt_o <= '0;
      mispred_cnt_o <= '0;
    end else if (pop) begin
      retired_cnt_o <= retired_cnt_o + CNT_W'(1);
      if (head_mp) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end

  // Queued mispredicts can never outnumber queued entries.
  a_mp_le_count: assert property (@(posedge ck_i) disable iff (rs_i)
    (mp_cnt <= fifo_count) && (fifo_count <= CNT_AW'(DEPTH)));

endmodule

// File: doc/bp_update_sched.md
# bp_update_sched

Branch-update scheduler between the execute unit and the branch predictor. It accepts resolved-branch records from execute with a valid/ready handshake and buffers them in an in-order queue. It drains one record per cycle onto the predictor's single update port, pausing while `hold_i` is asserted. It also tracks queued mispredicts for fetch and keeps retired-branch and mispredict performance counters.

## Interface
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `CNT_W`, 32: width of each performance counter.
- `ck_i` in 1: clock.
- `rs_i` in 1: reset, asynchronous, active-high.
- `ex_valid_i` in 1: execute presents a resolved branch.
- `ex_ready_o` out 1: scheduler can accept a record.
- `ex_source_i` in `INS_BUS_A`: PC of the branch.
- `ex_target_i` in `INS_BUS_A`: resolved target PC.
- `ex_taken_i`, `ex_call_i`, `ex_ret_i`, `ex_jmp_i`, `ex_mispredict_i` in 1 each: resolution flags.
- `hold_i` in 1: pause draining; the head entry is held.
- `branch_request_o` out 1: update strobe to the predictor.
- `branch_source_o`, `branch_target_o` out `INS_BUS_A`: fields of the head entry.
- `branch_is_taken_o`, `branch_is_call_o`, `branch_is_ret_o`, `branch_is_jmp_o`, `branch_mispredict_o` out 1: flags of the head entry.
- `mp_pending_o` out 1: at least one queued, unissued entry is a mispredict.
- `empty_o` out 1: queue empty.
- `retired_cnt_o` out `CNT_W`: number of updates issued.
- `mispred_cnt_o` out `CNT_W`: number of mispredict updates issued.

## Operation
- **Push:** occurs when `ex_valid_i & ex_ready_o`. The record is written at the tail.
- **Ready:** `ex_ready_o = ~full`. Ready does not depend on pop in the same cycle.
- **Issue:** `branch_request_o = ~empty & ~hold_i`.
  - When `branch_request_o` is high, the head is popped at the clock edge.
  - Entries are issued in strict FIFO order. There is no reordering, because the predictor's RAS indices rely on call/ret order.
- **Head visibility:** all `branch_*_o` fields show the head entry whenever the queue is non-empty, and all zero when empty. The predictor qualifies them with `branch_request_o`.
- **Occupancy:** count width is `$clog2(DEPTH+1)`.
  - Push and pop in the same cycle leave count unchanged.
  - Read and write pointers wrap modulo `DEPTH`.
- **Mispredict tracking:** `mp_cnt` counts queued mispredict entries.
  - +1 on a push with `ex_mispredict_i` set.
  - −1 on a pop whose head has the mispredict flag set.
  - Both in the same cycle leaves it unchanged.
  - `mp_pending_o = (mp_cnt != 0)`.
- **Performance counters:**
  - `retired_cnt_o` increments on every pop.
  - `mispred_cnt_o` increments on every pop of a mispredict entry.
  - Both wrap modulo 2^`CNT_W`.
- **Reset:** asynchronous. It clears pointers, count, `mp_cnt` and both counters.
  - Reset values: `ex_ready_o=1`, `empty_o=1`, `branch_request_o=0`, all fields 0, `mp_pending_o=0`, counters 0.
  - Reset mid-operation discards all queued entries. Any in-flight record is lost, and execute must re-synchronise through its own flush.

## Timing
- A record pushed at edge N is visible at the head and issuable in cycle N+1 at the earliest. There is no same-cycle bypass.
- Latency to issue is occupancy + 1 cycles, plus one cycle per cycle that `hold_i` is high.
- `branch_request_o` is combinational from `hold_i` and the registered empty flag. It has no path from the `ex_*` inputs.
- `ex_ready_o`, `empty_o`, `mp_pending_o` and the counters are registered, or decoded from registered state only.
- Full queue: `ex_ready_o=0` in the cycle after the DEPTH-th push. It rises in the cycle after the first pop.
- Empty queue with `hold_i` low: no request is issued, and a new push issues on the next cycle.
- `hold_i` toggling does not alter queue contents; the head is only consumed on a cycle with `branch_request_o` high.

## Structure
- Use `INS_BUS_A` from `defines.v`.
- Add to `defines.v`: `BPQ_ENTRY_W` (2×32+5 = 69) and the bit offsets of the five flags within an entry.
- Sub-module `bpq_fifo`: parameterised synchronous FIFO with `DEPTH` and `WIDTH`, push/pop/full/empty/count and async active-high reset.
- Top level holds packing/unpacking, `mp_cnt` and the performance counters.

## Test plan
- **Reset and idle:** assert `rs_i` mid-run with 3 entries queued → outputs return to their reset values immediately, `empty_o=1`, counters 0, and no `branch_request_o` afterwards.
- **Single record:** push one record (source 0x100, target 0x200, taken=1) at edge 0 with `hold_i=0` → `branch_request_o=1` with those fields in cycle 1, then `empty_o=1` in cycle 2 and `retired_cnt_o=1`.
- **Fill and stall:** with `DEPTH=4` and `hold_i=1`, push 5 back-to-back → first 4 accepted and `ex_ready_o=0` after the 4th. Release `hold_i` → 4 issues in order on consecutive cycles, and the 5th is accepted in the cycle after the first pop.
- **Mispredict tracking:** push taken/mispredict/taken/mispredict with hold → `mp_pending_o=1`. After draining 3 entries it is still 1; after the 4th it is 0, and `mispred_cnt_o=2`.
- **Concurrent push and pop:** keep the queue at occupancy 2 with a simultaneous push and pop every cycle for 20 cycles → count stays 2, order is preserved across pointer wrap, and `retired_cnt_o` advances by 20.
- **Counter wrap:** with `CNT_W=4`, issue 17 updates → `retired_cnt_o=1`.
